// File: rtl/keylock_pkg.sv
// Shared types and helpers for the programmable digit-sequence lock.
package keylock_pkg;

  localparam int unsigned DIGIT_W_DEF    = 4;
  localparam int unsigned CODE_LEN_DEF   = 6;
  localparam int unsigned MAX_CODE_BITS  = 256;
  localparam int unsigned MAX_DIGIT_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    UNLOCKED,
    LOCKOUT
  } state_t;

  // Digit idx of a packed code (digit 0 in the LSBs); the caller truncates to its digit width.
  function automatic logic [MAX_DIGIT_BITS-1:0] get_digit(
    input logic [MAX_CODE_BITS-1:0] code,
    input int unsigned              idx,
    input int unsigned              width
  );
    logic [MAX_DIGIT_BITS-1:0] mask;
    logic [MAX_DIGIT_BITS-1:0] d;
    mask = '1;
    mask = ~(mask << width);
    d    = MAX_DIGIT_BITS'(code >> (idx * width));
    return d & mask;
  endfunction

endpackage

// File: rtl/keylock_lockout_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module keylock_lockout_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/keylock_seq_fsm.sv
// Programmable digit-sequence lock with full-length entry, relock and fail counting.
// Optional lockout after MAX_FAILS consecutive failures: define KEYLOCK_LOCKOUT_EN.
module keylock_seq_fsm
  import keylock_pkg::*;
#(
  parameter int unsigned                    DIGIT_W        = DIGIT_W_DEF,
  parameter int unsigned                    CODE_LEN       = CODE_LEN_DEF,
  parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = 24'h652533,
  parameter int unsigned                    MAX_FAILS      = 3,
  parameter int unsigned                    LOCKOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key,
  input  logic                              relock,
  input  logic                              prog_we,
  input  logic [CODE_LEN*DIGIT_W-1:0]       prog_code,
  output logic                              locked,
  output logic                              fail,
  output logic                              lockout,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt
);

  localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned FCNT_W = $clog2(MAX_FAILS + 1);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d, fcnt_inc;
  logic                mism_q, mism_d;
  logic                locked_q, locked_d;
  logic                fail_q, fail_d;
  logic                lockout_q, lockout_d;
  logic                timer_load;
  logic                timer_done;
  logic [DIGIT_W-1:0]  exp_digit;
  logic                bad;

`ifdef KEYLOCK_LOCKOUT_EN
  keylock_lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .done  (timer_done)
  );
`else
  assign timer_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      code_q    <= DEFAULT_CODE;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      mism_q    <= 1'b0;
      locked_q  <= 1'b1;
      fail_q    <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      mism_q    <= mism_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
      lockout_q <= lockout_d;
    end
  end

  // In IDLE cnt_q is zero, so cnt_q selects the expected digit in both IDLE and ENTRY.
  assign exp_digit = DIGIT_W'(get_digit(MAX_CODE_BITS'(code_q), 32'(cnt_q), DIGIT_W));
  assign bad       = mism_q | (key != exp_digit);
  assign fcnt_inc  = (fcnt_q < FCNT_W'(MAX_FAILS)) ? fcnt_q + FCNT_W'(1) : fcnt_q;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    mism_d     = mism_q;
    locked_d   = locked_q;
    fail_d     = 1'b0;
    lockout_d  = lockout_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = ENTRY;
          cnt_d   = CNT_W'(1);
          mism_d  = (key != exp_digit);
        end
      end
      ENTRY: begin
        if (key_valid) begin
          if (cnt_q == CNT_W'(CODE_LEN - 1)) begin
            mism_d = 1'b0;
            if (!bad) begin
              state_d  = UNLOCKED;
              locked_d = 1'b0;
              fcnt_d   = '0;
              cnt_d    = CNT_W'(CODE_LEN);
            end else begin
              state_d = IDLE;
              fail_d  = 1'b1;
              fcnt_d  = fcnt_inc;
              cnt_d   = '0;
`ifdef KEYLOCK_LOCKOUT_EN
              if (fcnt_inc == FCNT_W'(MAX_FAILS)) begin
                state_d    = LOCKOUT;
                lockout_d  = 1'b1;
                timer_load = 1'b1;
              end
`endif
            end
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            mism_d = bad;
          end
        end
      end
      UNLOCKED: begin
        if (prog_we) begin
          code_d = prog_code;
        end
        if (relock) begin
          state_d  = IDLE;
          locked_d = 1'b1;
          cnt_d    = '0;
        end
      end
      LOCKOUT: begin
        if (timer_done) begin
          state_d   = IDLE;
          lockout_d = 1'b0;
          fcnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign locked    = locked_q;
  assign fail      = fail_q;
  assign lockout   = lockout_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_keylock_seq_fsm.sv
// Scenario bench for keylock_seq_fsm; expected outputs are queued per driven cycle.
module tb_keylock_seq_fsm;

  typedef struct packed {
    logic       locked;
    logic       fail;
    logic       lockout;
    logic [2:0] cnt;
  } out_t;

  localparam logic [23:0] CODE_DEF  = 24'h652533;
  localparam logic [23:0] CODE_ONES = 24'h111111;
  localparam logic [23:0] CODE_BAD  = 24'h652593;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key = '0;
  logic        relock = 1'b0;
  logic        prog_we = 1'b0;
  logic [23:0] prog_code = '0;
  logic        locked;
  logic        fail;
  logic        lockout;
  logic [2:0]  digit_cnt;

  out_t exp_q[$];
  out_t obs_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  keylock_seq_fsm #(
    .DIGIT_W        (4),
    .CODE_LEN       (6),
    .DEFAULT_CODE   (24'h652533),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key       (key),
    .relock    (relock),
    .prog_we   (prog_we),
    .prog_code (prog_code),
    .locked    (locked),
    .fail      (fail),
    .lockout   (lockout),
    .digit_cnt (digit_cnt)
  );

  function automatic out_t mk(input logic l, input logic f, input logic lo, input logic [2:0] c);
    return {l, f, lo, c};
  endfunction

  task automatic cyc(input logic kv, input logic [3:0] k, input logic rl, input logic pw,
                     input logic [23:0] pc, input out_t e);
    key_valid = kv;
    key       = k;
    relock    = rl;
    prog_we   = pw;
    prog_code = pc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back({locked, fail, lockout, digit_cnt});
    key_valid = 1'b0;
    relock    = 1'b0;
    prog_we   = 1'b0;
  endtask

  task automatic idle(input out_t e);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 24'h0, e);
  endtask

  task automatic enter(input logic [23:0] code, input out_t last);
    logic [3:0] d;
    for (int i = 0; i < 6; i++) begin
      d = code[i*4 +: 4];
      if (i < 5) cyc(1'b1, d, 1'b0, 1'b0, 24'h0, mk(1'b1, 1'b0, 1'b0, 3'(i + 1)));
      else       cyc(1'b1, d, 1'b0, 1'b0, 24'h0, last);
    end
  endtask

  task automatic test_reset();
    out_t e, o;
    reset = 1'b1;
    idle(mk(1, 0, 0, 0));
    idle(mk(1, 0, 0, 0));
    reset = 1'b0;
    idle(mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL reset[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_unlock();
    out_t e, o;
    enter(CODE_DEF, mk(0, 0, 0, 6));
    idle(mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL unlock[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_wrong();
    out_t e, o;
    enter(CODE_BAD, mk(1, 1, 0, 0));
    idle(mk(1, 0, 0, 0));
    idle(mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL wrong[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_prog();
    out_t e, o;
    enter(CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b1, 1'b1, CODE_ONES, mk(1, 0, 0, 0));
    enter(CODE_DEF, mk(1, 1, 0, 0));
    enter(CODE_ONES, mk(0, 0, 0, 6));
    cyc(1'b1, 4'h3, 1'b0, 1'b0, 24'h0, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b0, 1'b1, CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    enter(CODE_ONES, mk(1, 1, 0, 0));
    enter(CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL prog[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_lockout();
    out_t e, o;
    logic [23:0] c;
    c = CODE_DEF;
    enter(CODE_BAD, mk(1, 1, 0, 0));
    enter(CODE_BAD, mk(1, 1, 0, 0));
`ifdef KEYLOCK_LOCKOUT_EN
    enter(CODE_BAD, mk(1, 1, 1, 0));
    for (int i = 0; i < 6; i++) cyc(1'b1, c[i*4 +: 4], 1'b1, 1'b1, CODE_ONES, mk(1, 0, 1, 0));
    for (int i = 0; i < 9; i++) idle(mk(1, 0, 1, 0));
    idle(mk(1, 0, 0, 0));
`else
    enter(CODE_BAD, mk(1, 1, 0, 0));
    enter(CODE_BAD, mk(1, 1, 0, 0));
`endif
    enter(CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL lockout[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    out_t e, o;
    logic [23:0] c;
    c = CODE_DEF;
    for (int i = 0; i < 4; i++) cyc(1'b1, c[i*4 +: 4], 1'b0, 1'b0, 24'h0, mk(1, 0, 0, 3'(i + 1)));
    reset = 1'b1;
    idle(mk(1, 0, 0, 0));
    reset = 1'b0;
    cyc(1'b1, c[16 +: 4], 1'b0, 1'b0, 24'h0, mk(1, 0, 0, 1));
    cyc(1'b1, c[20 +: 4], 1'b0, 1'b0, 24'h0, mk(1, 0, 0, 2));
    reset = 1'b1;
    idle(mk(1, 0, 0, 0));
    reset = 1'b0;
    enter(CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b0, 1'b1, CODE_ONES, mk(0, 0, 0, 6));
    reset = 1'b1;
    idle(mk(1, 0, 0, 0));
    reset = 1'b0;
    enter(CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL reset_mid[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_ignored_and_gaps();
    out_t e, o;
    logic [23:0] c;
    c = CODE_DEF;
    cyc(1'b0, 4'h0, 1'b1, 1'b1, CODE_ONES, mk(1, 0, 0, 0));
    cyc(1'b1, c[3:0], 1'b0, 1'b0, 24'h0, mk(1, 0, 0, 1));
    cyc(1'b0, 4'h0, 1'b1, 1'b1, CODE_ONES, mk(1, 0, 0, 1));
    for (int i = 1; i < 6; i++) begin
      idle(mk(1, 0, 0, 3'(i)));
      idle(mk(1, 0, 0, 3'(i)));
      if (i < 5) cyc(1'b1, c[i*4 +: 4], 1'b0, 1'b0, 24'h0, mk(1, 0, 0, 3'(i + 1)));
      else       cyc(1'b1, c[i*4 +: 4], 1'b0, 1'b0, 24'h0, mk(0, 0, 0, 6));
    end
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL ignored[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    enter(CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b1, 4'h3, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    enter(CODE_BAD, mk(1, 1, 0, 0));
    enter(CODE_DEF, mk(0, 0, 0, 6));
    cyc(1'b1, 4'h4, 1'b0, 1'b0, 24'h0, mk(0, 0, 0, 6));
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 24'h0, mk(1, 0, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL back_to_back[%0d]: got l=%b f=%b lo=%b cnt=%0d want l=%b f=%b lo=%b cnt=%0d",
                            n, o.locked, o.fail, o.lockout, o.cnt, e.locked, e.fail, e.lockout, e.cnt);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong();
    test_prog();
    test_lockout();
    test_reset_mid();
    test_ignored_and_gaps();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
